// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory responder for the single-cycle ARM core.
//
// Decodes the core's data-bus address into word RAM (Addr[31]=0) or a small
// memory-mapped I/O page (Addr[31]=1) holding an LED register, a synchronised
// switch input and a programmable down-counting timer with a sticky expiry
// flag and an interrupt line.
//
// Loads are answered combinationally so the core closes a load in one cycle;
// every write and every state update happens on the rising edge of clk.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   MemWrite   store enable from the core
//   Addr       byte address (core ALUResult)
//   WriteData  store data
//   ReadData   load data, combinational from Addr and current state
//   sw_in      asynchronous switch inputs (synchronised internally)
//   led_out    LED register contents
//   timer_irq  expired AND irq_en
//
// MMIO map (offsets from 0x8000_0000):
//   0x00 LED     RW, low LED_W bits
//   0x04 SW      RO, synchronised sw_in, zero-extended
//   0x08 CTRL    RW, bit0 en, bit1 auto_reload, bit2 irq_en
//   0x0C LOAD    RW, a write also loads COUNT
//   0x10 COUNT   RO
//   0x14 STATUS  bit0 expired, sticky, write-1-to-clear
//   0x18/0x1C and any Addr[30:5] != 0 are unmapped: read 0, write ignored.

module dmem_mmio #(
  parameter int RAM_WORDS = 64,
  parameter int LED_W     = 16,
  parameter int SW_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              timer_irq
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_SW     = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_LOAD   = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // Storage
  logic [31:0]       ram_r [RAM_WORDS];
  logic [LED_W-1:0]  led_r;
  logic [SW_W-1:0]   sw_meta_r;
  logic [SW_W-1:0]   sw_sync_r;
  logic              en_r;
  logic              auto_r;
  logic              irq_en_r;
  logic [31:0]       load_r;
  logic [31:0]       count_r;
  logic              expired_r;
  logic              irq_r;

  // Decode
  logic              mmio_s;
  logic              mapped_s;
  logic [2:0]        reg_s;
  logic [AW-1:0]     ram_idx_s;
  logic              ram_we_s;
  logic              mmio_we_s;
  logic              wr_led_s;
  logic              wr_ctrl_s;
  logic              wr_load_s;
  logic              wr_status_s;

  // Next-state
  logic              en_nx_s;
  logic              auto_nx_s;
  logic              irq_en_nx_s;
  logic [31:0]       load_nx_s;
  logic [31:0]       count_nx_s;
  logic              expired_nx_s;
  logic              expire_s;
  logic [31:0]       rdata_s;

  // Byte-lane bits are deliberately ignored: the bus is word-only.
  logic              unused_addr_s;
  assign unused_addr_s = ^Addr[1:0];

  assign mmio_s    = Addr[31];
  assign mapped_s  = (Addr[30:5] == 26'd0);
  assign reg_s     = Addr[4:2];
  assign ram_idx_s = Addr[AW+1:2];

  // The RAM has no reset, so it must be gated here to keep a store that
  // coincides with reset from landing.
  assign ram_we_s    = MemWrite & ~mmio_s & ~reset;
  assign mmio_we_s   = MemWrite & mmio_s & mapped_s;
  assign wr_led_s    = mmio_we_s & (reg_s == REG_LED);
  assign wr_ctrl_s   = mmio_we_s & (reg_s == REG_CTRL);
  assign wr_load_s   = mmio_we_s & (reg_s == REG_LOAD);
  assign wr_status_s = mmio_we_s & (reg_s == REG_STATUS);

  // RAM write port; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_r[ram_idx_s] <= WriteData;
    end
  end

  // Combinational load path: reflects pre-edge state, independent of MemWrite.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (!mmio_s) begin
      rdata_s = ram_r[ram_idx_s];
    end else if (mapped_s) begin
      case (reg_s)
        REG_LED:    rdata_s = 32'(led_r);
        REG_SW:     rdata_s = 32'(sw_sync_r);
        REG_CTRL:   rdata_s = {29'd0, irq_en_r, auto_r, en_r};
        REG_LOAD:   rdata_s = load_r;
        REG_COUNT:  rdata_s = count_r;
        REG_STATUS: rdata_s = {31'd0, expired_r};
        default:    rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign ReadData = rdata_s;

  // Timer next-state. The hardware tick is computed first, then CPU writes
  // overlay it: a LOAD write beats the tick, a CTRL write beats the
  // one-shot clear of en, and a fresh expiry beats a write-1-clear.
  always_comb begin
    en_nx_s      = en_r;
    auto_nx_s    = auto_r;
    irq_en_nx_s  = irq_en_r;
    load_nx_s    = load_r;
    count_nx_s   = count_r;
    expired_nx_s = expired_r;
    expire_s     = 1'b0;

    if (en_r) begin
      if (count_r > 32'd1) begin
        count_nx_s = count_r - 32'd1;
      end else begin
        expire_s = 1'b1;
        if (auto_r) begin
          count_nx_s = load_r;
        end else begin
          count_nx_s = 32'd0;
          en_nx_s    = 1'b0;
        end
      end
    end else begin
      count_nx_s = count_r;
    end

    if (wr_load_s) begin
      load_nx_s  = WriteData;
      count_nx_s = WriteData;
    end else begin
      load_nx_s = load_r;
    end

    if (wr_ctrl_s) begin
      en_nx_s     = WriteData[0];
      auto_nx_s   = WriteData[1];
      irq_en_nx_s = WriteData[2];
    end else begin
      auto_nx_s   = auto_r;
      irq_en_nx_s = irq_en_r;
    end

    if (expire_s) begin
      expired_nx_s = 1'b1;
    end else if (wr_status_s && WriteData[0]) begin
      expired_nx_s = 1'b0;
    end else begin
      expired_nx_s = expired_r;
    end
  end

  // Timer, LED and interrupt registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_r     <= '0;
      en_r      <= 1'b0;
      auto_r    <= 1'b0;
      irq_en_r  <= 1'b0;
      load_r    <= 32'd0;
      count_r   <= 32'd0;
      expired_r <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      if (wr_led_s) begin
        led_r <= WriteData[LED_W-1:0];
      end
      en_r      <= en_nx_s;
      auto_r    <= auto_nx_s;
      irq_en_r  <= irq_en_nx_s;
      load_r    <= load_nx_s;
      count_r   <= count_nx_s;
      expired_r <= expired_nx_s;
      // Registered from the next-state values so it always equals
      // expired & irq_en with no Addr-dependent path.
      irq_r     <= expired_nx_s & irq_en_nx_s;
    end
  end

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_r <= '0;
      sw_sync_r <= '0;
    end else begin
      sw_meta_r <= sw_in;
      sw_sync_r <= sw_meta_r;
    end
  end

  assign led_out   = led_r;
  assign timer_irq = irq_r;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: expected read values are queued when a
// read is issued and popped for comparison when ReadData is sampled.
module tb_dmem_mmio;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_SW     = 32'h8000_0004;
  localparam logic [31:0] A_CTRL   = 32'h8000_0008;
  localparam logic [31:0] A_LOAD   = 32'h8000_000C;
  localparam logic [31:0] A_COUNT  = 32'h8000_0010;
  localparam logic [31:0] A_STATUS = 32'h8000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        timer_irq;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got;
  logic [31:0] exp;

  dmem_mmio #(.RAM_WORDS(64), .LED_W(16), .SW_W(16)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .sw_in(sw_in),
    .led_out(led_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Advance one rising edge and settle well away from it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Addr = a; WriteData = d;
    step();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemWrite = 1'b0; Addr = a;
    #1;
    d = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [5];
    addrs = '{A_LED, A_CTRL, A_LOAD, A_COUNT, A_STATUS};
    reset = 1'b1; MemWrite = 1'b0; Addr = 32'd0; WriteData = 32'd0; sw_in = 16'd0;
    #2;
    exp_q.push_back(32'd0); got = {16'd0, led_out}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_led_out got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); got = {31'd0, timer_irq}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL reset_irq got=%h exp=%h", got, exp); end
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'd0); rd(addrs[i], got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL reset_reg%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_ram();
    logic [31:0] ra [4];
    logic [31:0] rv [4];
    ra = '{32'h0000_0010, 32'h0000_0014, 32'h0000_0110, 32'h0000_0013};
    rv = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_0014, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(rv[i]); rd(ra[i], got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL ram_rd%0d got=%h exp=%h", i, got, exp); end
    end
    // Read during a write to the same word sees the old value.
    MemWrite = 1'b1; Addr = 32'h0000_0010; WriteData = 32'h0BAD_F00D;
    #1;
    exp_q.push_back(32'hDEAD_BEEF); got = ReadData; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ram_rdw_old got=%h exp=%h", got, exp); end
    step();
    MemWrite = 1'b0;
    exp_q.push_back(32'h0BAD_F00D); rd(32'h0000_0010, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ram_rdw_new got=%h exp=%h", got, exp); end
  endtask

  task automatic test_led_sw();
    logic [31:0] swv [3];
    swv = '{32'd0, 32'd0, 32'h0000_1234};
    wr(A_LED, 32'hFFFF_A5A5);
    exp_q.push_back(32'h0000_A5A5); got = {16'd0, led_out}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL led_out got=%h exp=%h", got, exp); end
    exp_q.push_back(32'h0000_A5A5); rd(A_LED, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL led_rd got=%h exp=%h", got, exp); end
    sw_in = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(swv[i]); rd(A_SW, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL sw_edge%0d got=%h exp=%h", i, got, exp); end
      if (i < 2) step();
    end
  endtask

  task automatic test_timer_oneshot();
    logic [31:0] cnt [5];
    logic [31:0] st [5];
    cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    st  = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1};
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h0000_0001);
    exp_q.push_back(32'd1); rd(A_CTRL, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL os_ctrl got=%h exp=%h", got, exp); end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(cnt[i]); rd(A_COUNT, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL os_count%0d got=%h exp=%h", i, got, exp); end
      exp_q.push_back(st[i]); rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL os_status%0d got=%h exp=%h", i, got, exp); end
      if (i < 4) step();
    end
    exp_q.push_back(32'd0); rd(A_CTRL, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL os_en_clear got=%h exp=%h", got, exp); end
    wr(A_STATUS, 32'd1);
    exp_q.push_back(32'd0); rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL os_w1c got=%h exp=%h", got, exp); end
  endtask

  task automatic test_timer_reload();
    logic [31:0] cnt [5];
    logic        irq [5];
    cnt = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd4};
    irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    wr(A_LOAD, 32'd4);
    wr(A_CTRL, 32'h0000_0007);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(cnt[i]); rd(A_COUNT, got); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL ar_count%0d got=%h exp=%h", i, got, exp); end
      exp_q.push_back({31'd0, irq[i]}); got = {31'd0, timer_irq}; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin failures++; $display("FAIL ar_irq%0d got=%h exp=%h", i, got, exp); end
      if (i < 4) step();
    end
    wr(A_STATUS, 32'd0);   // count 4->3, writing 0 must not clear
    exp_q.push_back(32'd1); rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_w0 got=%h exp=%h", got, exp); end
    step(); step();        // count 3->2->1
    wr(A_STATUS, 32'd1);   // expiry on the same edge as the clear
    exp_q.push_back(32'd1); rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_set_wins got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd4); rd(A_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_reload got=%h exp=%h", got, exp); end
    wr(A_STATUS, 32'd1);   // count 4->3, clear takes effect
    exp_q.push_back(32'd0); rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_clear got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); got = {31'd0, timer_irq}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_irq_drop got=%h exp=%h", got, exp); end
  endtask

  task automatic test_load_override();
    wr(A_LOAD, 32'd9);     // tick would have given 2
    exp_q.push_back(32'd9); rd(A_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL lo_count got=%h exp=%h", got, exp); end
    step();
    exp_q.push_back(32'd8); rd(A_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL lo_tick got=%h exp=%h", got, exp); end
    wr(A_CTRL, 32'd0);     // last tick 8->7, then hold
    step();
    exp_q.push_back(32'd7); rd(A_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL lo_hold got=%h exp=%h", got, exp); end
    // CTRL write on a one-shot expiry edge keeps en set.
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'd1);
    step();                // count 2->1
    wr(A_CTRL, 32'd1);     // expiry edge
    exp_q.push_back(32'd1); rd(A_CTRL, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL co_en_kept got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd1); rd(A_STATUS, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL co_expired got=%h exp=%h", got, exp); end
    wr(A_CTRL, 32'd0);
    wr(A_STATUS, 32'd1);
  endtask

  task automatic test_unmapped_reset();
    wr(A_LOAD, 32'd10);
    wr(A_CTRL, 32'd1);
    step(); step(); step();
    exp_q.push_back(32'd7); rd(A_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL um_mid got=%h exp=%h", got, exp); end
    wr(32'h8000_0018, 32'hFFFF_FFFF);
    exp_q.push_back(32'd0); rd(32'h8000_0018, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL um_rd18 got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd1); rd(A_CTRL, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL um_ctrl got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd10); rd(A_LOAD, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL um_load got=%h exp=%h", got, exp); end
    wr(32'h8000_0020, 32'h0000_FFFF);   // would alias LED if Addr[30:5] were ignored
    exp_q.push_back(32'h0000_A5A5); got = {16'd0, led_out}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL um_led got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(32'h8000_0020, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL um_rd20 got=%h exp=%h", got, exp); end
    // Asynchronous reset between edges.
    reset = 1'b1;
    #1;
    exp_q.push_back(32'd0); got = {16'd0, led_out}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_led_out got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(A_COUNT, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_count got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(A_CTRL, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_ctrl got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); got = {31'd0, timer_irq}; exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL ar_irq got=%h exp=%h", got, exp); end
    // Writes while reset is held must not commit.
    wr(32'h0000_0010, 32'h5555_5555);
    wr(A_LED, 32'h0000_FFFF);
    reset = 1'b0;
    exp_q.push_back(32'h0BAD_F00D); rd(32'h0000_0010, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL rst_ram_wr got=%h exp=%h", got, exp); end
    exp_q.push_back(32'd0); rd(A_LED, got); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin failures++; $display("FAIL rst_led_wr got=%h exp=%h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led_sw();
    test_timer_oneshot();
    test_timer_reload();
    test_load_override();
    test_unmapped_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory responder for the single-cycle ARM core. It answers the core's data bus: MemWrite, the ALUResult address, WriteData and ReadData.
- Decodes each address to word RAM or to a memory-mapped I/O page.
- The I/O page holds an LED output register, a synchronised switch input, and a programmable down-counting timer with sticky expiry and an interrupt line.
- Reads are combinational so the single-cycle core closes its load in one cycle. All writes and all state updates take effect on the rising edge of clk.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, at most 1024
- LED_W, 16, width of the LED register
- SW_W, 16, width of the switch input

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- MemWrite  in  1  write enable from the core
- Addr  in  32  byte address, driven by the core's ALUResult
- WriteData  in  32  store data
- ReadData  out  32  load data, combinational
- sw_in  in  SW_W  asynchronous switch inputs
- led_out  out  LED_W  LED register contents
- timer_irq  out  1  expired AND irq_en

Behaviour:
Address decode:
- Addr[31]=0 selects RAM; index = Addr[log2(RAM_WORDS)+1:2]. Upper address bits alias. Addr[1:0] is ignored (word access only).
- Addr[31]=1 selects MMIO; register = Addr[4:2]. Offsets 0x18 and 0x1C, and any Addr[30:5]≠0, are unmapped: read 0, write ignored.

MMIO map (offsets from 0x8000_0000):
- 0x00 LED: RW, low LED_W bits; upper bits read 0.
- 0x04 SW: RO; returns sw_in after a 2-flop synchroniser, zero-extended.
- 0x08 CTRL: RW; bit0 en, bit1 auto_reload, bit2 irq_en; other bits read 0.
- 0x0C LOAD: RW; a write loads both LOAD and COUNT.
- 0x10 COUNT: RO; writes ignored.
- 0x14 STATUS: bit0 expired, sticky; writing 1 to bit0 clears it, writing 0 has no effect.

Reset (asynchronous, immediate):
- led_out, the sync flops, CTRL, LOAD, COUNT and expired all go to 0.
- timer_irq=0.
- RAM contents are not reset and are undefined until written.
- Reset during a timer countdown aborts it. No write is committed on an edge where reset is asserted.

Read path:
- ReadData is purely combinational from Addr and current state, independent of MemWrite.
- A read in the same cycle as a write to the same location returns the old value; the new value is visible the cycle after the edge.

Timer, evaluated each rising edge while en=1:
- COUNT>1: COUNT←COUNT−1.
- COUNT≤1: expired←1; COUNT←auto_reload ? LOAD : 0; if auto_reload=0 then en←0.
- Auto-reload period is therefore LOAD cycles. Enabling with COUNT=0 expires on the first edge.
- While en=0, COUNT holds.

Same-edge priority:
- A CPU write to LOAD overrides the timer tick (COUNT←WriteData).
- A CPU write to CTRL overrides the hardware clear of en.
- Hardware expiry-set wins over a write-1-clear to STATUS (expired stays 1).

Output:
- timer_irq is registered-state derived: expired & irq_en. No glitch from the Addr path.

Test Plan:
1. Write 0xDEADBEEF to 0x0000_0010, then 0x12345678 to 0x0000_0014; read both back → ReadData matches each. Read 0x0000_0110 (with RAM_WORDS=64) → 0xDEADBEEF via aliasing.
2. Write 0xFFFF_A5A5 to LED → led_out=0xA5A5 after the edge; LED reads back 0x0000_A5A5. Set sw_in=0x1234 → SW reads 0x1234 from the 2nd edge onward, 0 before.
3. LOAD=3, CTRL=0x1 → COUNT reads 3,2,1,0 on successive edges. expired=1 on the edge where COUNT goes 1→0; en clears; COUNT stays 0.
4. LOAD=4, CTRL=0x7 → COUNT reads 4,3,2,1,4,3… and timer_irq rises with the first 1→4 transition. Write 1 to STATUS → irq drops; expiry on the same edge as that clear → expired remains 1.
5. Timer mid-count (COUNT=7) plus an unmapped write to 0x8000_0018 → no state change; 0x8000_0018 reads 0. Assert reset asynchronously between edges → COUNT, CTRL and led_out read 0 immediately, timer_irq=0.
6. A write to LOAD=9 on the same edge the timer would tick → COUNT=9 next cycle, not 8.
